// File: rtl/vseq_pkg.sv
// vseq_pkg: shared constants, state encoding and helpers for the vector memory sequencer.
package vseq_pkg;

   localparam int VSEQ_LANES  = 16;
   localparam int VSEQ_LANE_W = 8;
   localparam int VSEQ_CNT_W  = 5;
   localparam int VSEQ_IDX_W  = 4;
   localparam int VSEQ_VEC_W  = VSEQ_LANES * VSEQ_LANE_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } vseq_state_t;

   // True when a lane counter points at the final byte lane of a vector.
   function automatic logic is_last_lane(input logic [VSEQ_CNT_W-1:0] cnt);
      return cnt == VSEQ_CNT_W'(VSEQ_LANES - 1);
   endfunction

endpackage

// File: rtl/vseq_lane_packer.sv
// vseq_lane_packer: aligns read strobes with returning bytes (RD_LAT-deep valid pipe)
// and assembles the returned bytes into a 128-bit vector, lane j at bits [8j+7:8j].
module vseq_lane_packer
   import vseq_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   issue_re,
   input  logic [VSEQ_LANE_W-1:0] rdata,
   output logic [VSEQ_CNT_W-1:0]  cap_cnt_next,
   output logic [VSEQ_VEC_W-1:0]  asm_next
);

   logic [RD_LAT-1:0]      vld_q, vld_d;
   logic [VSEQ_CNT_W-1:0]  cnt_q, cnt_d;
   logic [VSEQ_VEC_W-1:0]  asm_q, asm_d;
   logic [VSEQ_LANES-1:0]  lane_hit;
   logic                   cap_vld;

   // The oldest pipe stage marks the cycle in which mem_rdata carries a valid byte.
   assign cap_vld = vld_q[RD_LAT-1];

   genvar gi;
   generate
      for (gi = 0; gi < VSEQ_LANES; gi++) begin : g_hit
         assign lane_hit[gi] = cap_vld && (cnt_q == VSEQ_CNT_W'(gi));
      end
   endgenerate

   // Shift the read strobe down the valid pipe, one stage per cycle.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = issue_re;
      for (int k = 1; k < RD_LAT; k++) begin
         vld_d[k] = vld_q[k-1];
      end
   end

   // Capture counter and byte-lane write of the assembly register.
   always_comb begin
      cnt_d = cnt_q;
      asm_d = asm_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cap_vld) begin
         cnt_d = cnt_q + VSEQ_CNT_W'(1);
      end
      for (int k = 0; k < VSEQ_LANES; k++) begin
         if (lane_hit[k]) begin
            asm_d[k*VSEQ_LANE_W +: VSEQ_LANE_W] = rdata;
         end
      end
   end

   // State registers; reset flushes in-flight read strobes so an aborted load leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q <= '0;
         cnt_q <= '0;
         asm_q <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

   assign cap_cnt_next = cnt_d;
   assign asm_next     = asm_d;

endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: turns one 128-bit vector load/store from the MEM stage into
// 16 consecutive byte accesses on data-memory port b, stalling the pipeline meanwhile.
// Optional feature: define VSEQ_BOUNDS_CHECK_EN to reject vectors that run past MEM_DEPTH.
module vector_mem_sequencer
   import vseq_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int LANES     = VSEQ_LANES,
   parameter int LANE_W    = VSEQ_LANE_W,
   parameter int RD_LAT    = 1,
   parameter int MEM_DEPTH = 65536
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic                    req_write,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [LANES*LANE_W-1:0] req_wdata,
   output logic                    req_ready,
   output logic                    stall,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_we,
   output logic                    mem_re,
   output logic [LANE_W-1:0]       mem_wdata,
   input  logic [LANE_W-1:0]       mem_rdata,
   output logic                    rsp_valid,
   output logic [LANES*LANE_W-1:0] rsp_rdata,
   output logic                    err
);

   localparam int VEC_W = LANES * LANE_W;

   vseq_state_t            state_q, state_d;
   logic [VSEQ_CNT_W-1:0]  issue_q, issue_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [VEC_W-1:0]       wdata_q, wdata_d;
   logic [VEC_W-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic                   bounds_bad;
   logic [VSEQ_CNT_W-1:0]  cap_cnt_next;
   logic [VEC_W-1:0]       asm_next;
   logic [LANE_W-1:0]      lane_bytes [LANES];

   // Byte lanes of the latched store data; lane 0 is the least significant byte.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_bytes[gi] = wdata_q[gi*LANE_W +: LANE_W];
      end
   endgenerate

`ifdef VSEQ_BOUNDS_CHECK_EN
   // Last byte address computed wide so a wrapping vector is caught instead of aliased.
   logic [31:0] last_addr;
   assign last_addr  = 32'(req_addr) + 32'(LANES - 1);
   assign bounds_bad = last_addr > 32'(MEM_DEPTH - 1);
`else
   logic unused_depth;
   assign unused_depth = (MEM_DEPTH > 0);
   assign bounds_bad   = 1'b0;
`endif

   assign accept = req_valid && req_ready;

   vseq_lane_packer #(
      .RD_LAT (RD_LAT)
   ) u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .issue_re     (mem_re),
      .rdata        (mem_rdata),
      .cap_cnt_next (cap_cnt_next),
      .asm_next     (asm_next)
   );

   // Next-state logic: accept, issue 16 bytes, wait for read data, then pulse completion.
   always_comb begin
      state_d     = state_q;
      issue_d     = issue_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      err_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               base_d  = req_addr;
               wdata_d = req_wdata;
               issue_d = '0;
               if (bounds_bad) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else if (req_write) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_WRITE: begin
            if (is_last_lane(issue_q)) begin
               issue_d = '0;
               state_d = ST_DONE;
            end else begin
               issue_d = issue_q + VSEQ_CNT_W'(1);
            end
         end
         ST_READ: begin
            if (is_last_lane(issue_q)) begin
               issue_d = '0;
               state_d = ST_DRAIN;
            end else begin
               issue_d = issue_q + VSEQ_CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            // Look at the next capture count so the final byte and the response land together.
            if (cap_cnt_next == VSEQ_CNT_W'(LANES)) begin
               rsp_rdata_d = asm_next;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Port outputs decoded from the current state; handshake outputs forced low while in reset.
   always_comb begin
      req_ready = reset && (state_q == ST_IDLE);
      stall     = reset && ((state_q == ST_WRITE) || (state_q == ST_READ) ||
                            (state_q == ST_DRAIN) || ((state_q == ST_IDLE) && req_valid));
      mem_we    = (state_q == ST_WRITE);
      mem_re    = (state_q == ST_READ);
      mem_addr  = '0;
      mem_wdata = '0;
      if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
         mem_addr = base_q + ADDR_W'(issue_q);
      end
      if (state_q == ST_WRITE) begin
         mem_wdata = lane_bytes[issue_q[VSEQ_IDX_W-1:0]];
      end
      rsp_valid = (state_q == ST_DONE);
      err       = (state_q == ST_DONE) && err_q;
      rsp_rdata = rsp_rdata_q;
   end

   // State registers; synchronous active-low reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         issue_q     <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_q     <= issue_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: table-driven vectors plus hand sequences for reset abort
// and back-to-back requests. DUT A uses RD_LAT=1, DUT B uses RD_LAT=3.
module tb_vector_mem_sequencer;

   typedef struct {
      logic         sel;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      int           exp_cyc;
      int           exp_acc;
      logic         exp_err;
      logic [127:0] exp_rdata;
   } vec_t;

   localparam logic [127:0] D1 = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] D2 = 128'h5F5E5D5C5B5A59585756555453525150;
   localparam logic [127:0] PA = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         sel;
   logic         req_valid, req_write;
   logic [15:0]  req_addr;
   logic [127:0] req_wdata;
   logic         req_valid_a, req_valid_b;

   logic         req_ready_a, stall_a, mem_we_a, mem_re_a, rsp_valid_a, err_a;
   logic [15:0]  mem_addr_a;
   logic [7:0]   mem_wdata_a, mem_rdata_a;
   logic [127:0] rsp_rdata_a;
   logic         req_ready_b, stall_b, mem_we_b, mem_re_b, rsp_valid_b, err_b;
   logic [15:0]  mem_addr_b;
   logic [7:0]   mem_wdata_b, mem_rdata_b;
   logic [127:0] rsp_rdata_b;

   assign req_valid_a = req_valid && !sel;
   assign req_valid_b = req_valid && sel;

   vector_mem_sequencer #(.RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a), .stall(stall_a),
      .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_re(mem_re_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .err(err_a)
   );

   vector_mem_sequencer #(.RD_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b), .stall(stall_b),
      .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_re(mem_re_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .err(err_b)
   );

   // Observed view of whichever DUT the current vector targets.
   logic         o_req_ready, o_stall, o_mem_we, o_mem_re, o_rsp_valid, o_err;
   logic [15:0]  o_mem_addr;
   logic [7:0]   o_mem_wdata;
   logic [127:0] o_rsp_rdata;
   assign o_req_ready = sel ? req_ready_b : req_ready_a;
   assign o_stall     = sel ? stall_b     : stall_a;
   assign o_mem_we    = sel ? mem_we_b    : mem_we_a;
   assign o_mem_re    = sel ? mem_re_b    : mem_re_a;
   assign o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
   assign o_err       = sel ? err_b       : err_a;
   assign o_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
   assign o_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
   assign o_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

   // Byte memories behind each DUT: A returns data 1 cycle after mem_re, B after 3.
   logic [7:0] mem_a [0:65535];
   logic [7:0] mem_b [0:65535];
   logic [7:0] rd_a, rd_b1, rd_b2, rd_b3;
   always @(posedge clk) begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      rd_a  <= mem_a[mem_addr_a];
      rd_b1 <= mem_b[mem_addr_b];
      rd_b2 <= rd_b1;
      rd_b3 <= rd_b2;
   end
   assign mem_rdata_a = rd_a;
   assign mem_rdata_b = rd_b3;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Apply one request (accept edge ends cycle 0) and check every port access and the response.
   task automatic run_op(input vec_t v, input string tag);
      int          n_acc = 0;
      int          first = -1;
      int          got   = -1;
      logic        both  = 1'b0;
      logic        g_err = 1'b0;
      logic        g_stl = 1'b1;
      logic [15:0] ea;
      logic [127:0] sh;
      @(posedge clk); #1;
      sel = v.sel; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      #1;
      check({tag, " ready_c0"}, 128'(o_req_ready), 128'(1));
      check({tag, " stall_c0"}, 128'(o_stall), 128'(1));
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (c == 1) req_valid = 1'b0;
         #1;
         if (o_mem_we && o_mem_re) both = 1'b1;
         if (o_mem_we || o_mem_re) begin
            if (first < 0) first = c;
            ea = v.addr + 16'(n_acc);
            check($sformatf("%s addr%0d", tag, n_acc), 128'(o_mem_addr), 128'(ea));
            if (v.wr) begin
               sh = v.wdata >> (8 * n_acc);
               check($sformatf("%s we%0d", tag, n_acc), 128'(o_mem_we), 128'(1));
               check($sformatf("%s byte%0d", tag, n_acc), 128'(o_mem_wdata), 128'(sh[7:0]));
            end else begin
               check($sformatf("%s re%0d", tag, n_acc), 128'(o_mem_re), 128'(1));
            end
            n_acc++;
         end
         if (o_rsp_valid) begin
            got   = c;
            g_err = o_err;
            g_stl = o_stall;
            break;
         end
      end
      check({tag, " rsp_cycle"}, 128'(got), 128'(v.exp_cyc));
      check({tag, " n_access"}, 128'(n_acc), 128'(v.exp_acc));
      if (v.exp_acc > 0) check({tag, " first_access"}, 128'(first), 128'(1));
      check({tag, " we_re_excl"}, 128'(both), 128'(0));
      check({tag, " err"}, 128'(g_err), 128'(v.exp_err));
      check({tag, " stall_done"}, 128'(g_stl), 128'(0));
      check({tag, " rdata"}, o_rsp_rdata, v.exp_rdata);
      @(posedge clk); #2;
      check({tag, " rsp_pulse"}, 128'(o_rsp_valid), 128'(0));
      check({tag, " ready_after"}, 128'(o_req_ready), 128'(1));
      $display("op %s: dut=%0d wr=%0d base=%h rsp_cycle=%0d accesses=%0d err=%0d rdata=%h",
               tag, v.sel, v.wr, v.addr, got, n_acc, g_err, o_rsp_rdata);
   endtask

   vec_t vecs [7];
   vec_t hv;
   int   n_we, n_re, rsp1, rsp2;
   logic early_ready;
   logic [127:0] rd2;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 16'h0100, D1, 17, 16, 1'b0, 128'h0};
      vecs[1] = '{1'b0, 1'b0, 16'h0200, '0, 18, 16, 1'b0, PA};
      vecs[2] = '{1'b0, 1'b0, 16'h0100, '0, 18, 16, 1'b0, D1};
`ifdef VSEQ_BOUNDS_CHECK_EN
      vecs[3] = '{1'b0, 1'b1, 16'hFFF8, D2, 1, 0, 1'b1, D1};
      vecs[4] = '{1'b0, 1'b0, 16'hFFF8, '0, 1, 0, 1'b1, D1};
      vecs[5] = '{1'b0, 1'b1, 16'hFFF0, D1, 17, 16, 1'b0, D1};
`else
      vecs[3] = '{1'b0, 1'b1, 16'hFFF8, D2, 17, 16, 1'b0, D1};
      vecs[4] = '{1'b0, 1'b0, 16'hFFF8, '0, 18, 16, 1'b0, D2};
      vecs[5] = '{1'b0, 1'b1, 16'hFFF0, D1, 17, 16, 1'b0, D2};
`endif
      vecs[6] = '{1'b1, 1'b0, 16'h0200, '0, 20, 16, 1'b0, PA};

      for (int k = 0; k < 16; k++) begin
         mem_a[16'h0200 + k] <= 8'(8'hA0 + k);
         mem_b[16'h0200 + k] <= 8'(8'hA0 + k);
      end

      reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outs_a", 128'({req_ready_a, stall_a, mem_addr_a, mem_we_a, mem_re_a,
                                  mem_wdata_a, rsp_valid_a, err_a}), 128'(0));
      check("reset outs_b", 128'({req_ready_b, stall_b, mem_addr_b, mem_we_b, mem_re_b,
                                  mem_wdata_b, rsp_valid_b, err_b}), 128'(0));
      check("reset rdata_a", rsp_rdata_a, 128'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("release ready_a", 128'(req_ready_a), 128'(1));
      $display("op reset: outputs checked");

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i], $sformatf("v%0d", i));
      end

      // Reset asserted in cycle 6 of a store: the store stops and everything reads zero.
      @(posedge clk); #1;
      sel = 1'b0; req_write = 1'b1; req_addr = 16'h0300; req_wdata = D1; req_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) req_valid = 1'b0;
      end
      #1;
      check("mid_rst we_c6", 128'(mem_we_a), 128'(1));
      reset = 1'b0;
      for (int c = 7; c <= 8; c++) begin
         @(posedge clk); #2;
         check($sformatf("mid_rst outs_c%0d", c),
               128'({req_ready_a, stall_a, mem_addr_a, mem_we_a, mem_re_a, mem_wdata_a,
                     rsp_valid_a, err_a}), 128'(0));
         check($sformatf("mid_rst rdata_c%0d", c), rsp_rdata_a, 128'h0);
      end
      reset = 1'b1;
      $display("op mid_rst: store aborted at cycle 6");
      hv = '{1'b0, 1'b1, 16'h0300, D2, 17, 16, 1'b0, 128'h0};
      run_op(hv, "post_rst_st");
      hv = '{1'b0, 1'b0, 16'h0300, '0, 18, 16, 1'b0, D2};
      run_op(hv, "post_rst_ld");

      // req_valid held through DONE; a new load is presented in the IDLE cycle after rsp_valid.
      @(posedge clk); #1;
      sel = 1'b0; req_write = 1'b1; req_addr = 16'h0400; req_wdata = D2; req_valid = 1'b1;
      n_we = 0; n_re = 0; rsp1 = -1; rsp2 = -1; early_ready = 1'b0; rd2 = '0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         if (rsp1 > 0 && c == rsp1 + 1) begin
            check("b2b ready_after_done", 128'(req_ready_a), 128'(1));
            req_write = 1'b0;
         end
         if (rsp1 > 0 && c == rsp1 + 2) req_valid = 1'b0;
         #1;
         if (mem_we_a) n_we++;
         if (mem_re_a) n_re++;
         if (rsp1 < 0 && req_ready_a) early_ready = 1'b1;
         if (rsp_valid_a) begin
            if (rsp1 < 0) begin
               rsp1 = c;
               check("b2b stall_done", 128'(stall_a), 128'(0));
            end else begin
               rsp2 = c;
               rd2  = rsp_rdata_a;
               break;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b rsp1_cycle", 128'(rsp1), 128'(17));
      check("b2b rsp2_cycle", 128'(rsp2), 128'(36));
      check("b2b n_we", 128'(n_we), 128'(16));
      check("b2b n_re", 128'(n_re), 128'(16));
      check("b2b early_ready", 128'(early_ready), 128'(0));
      check("b2b rdata", rd2, D2);
      $display("op b2b: rsp1=%0d rsp2=%0d we=%0d re=%0d rdata=%h", rsp1, rsp2, n_we, n_re, rd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
